// File: rtl/axi_inf_read_state_core.sv
// AXI4 read master core: one AR per accepted request, each R beat is pushed into the downstream FIFO.
// Latency: read_req to arvalid 1 cycle; R beats are pushed in the same cycle they are accepted.
// Backpressure: sink_almost_full drops rready the same cycle; pend_in holds off new requests.
module axi_inf_read_state_core #(
    parameter int IDSIZE    = 4,
    parameter int ID        = 0,
    parameter int LSIZE     = 9,
    parameter int ASIZE     = 29,
    parameter int AXI_DSIZE = 256
) (
    input  logic                 axi_aclk,
    input  logic                 axi_resetn,
    input  logic                 read_req,
    input  logic [LSIZE-1:0]     req_len,
    input  logic [ASIZE-1:0]     req_addr,
    output logic                 req_resp,
    output logic                 req_done,
    input  logic                 pend_in,
    output logic                 pend_out,
    input  logic                 sink_almost_full,
    output logic                 push_data_en,
    output logic [AXI_DSIZE-1:0] push_data,
    output logic                 push_last,
    output logic                 resp_err,
    output logic [IDSIZE-1:0]    axi_arid,
    output logic [ASIZE-1:0]     axi_araddr,
    output logic [LSIZE-1:0]     axi_arlen,
    output logic [2:0]           axi_arsize,
    output logic [1:0]           axi_arburst,
    output logic                 axi_arlock,
    output logic [3:0]           axi_arcache,
    output logic [2:0]           axi_arprot,
    output logic [3:0]           axi_arqos,
    output logic                 axi_arvalid,
    input  logic                 axi_arready,
    input  logic [IDSIZE-1:0]    axi_rid,
    input  logic [AXI_DSIZE-1:0] axi_rdata,
    input  logic [1:0]           axi_rresp,
    input  logic                 axi_rlast,
    input  logic                 axi_rvalid,
    output logic                 axi_rready
);

    localparam logic [IDSIZE-1:0] ID_V   = IDSIZE'(ID);
    localparam logic [2:0]        ARSIZE = 3'($clog2(AXI_DSIZE / 8));

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [LSIZE-1:0] beat_cnt;
    logic             start;
    logic             accept;
    logic             last_beat;
    logic             beat_err;

    // A new burst is only taken from IDLE and only while the sibling core is off the bus
    assign start  = (state == S_IDLE) && read_req && !pend_in;
    assign accept = axi_rvalid && axi_rready;
    // The counter reaching arlen ends the burst even without rlast, so the counter never wraps
    assign last_beat = axi_rlast || (beat_cnt == axi_arlen);
    assign beat_err  = (axi_rresp != 2'b00) || (axi_rid != ID_V) ||
                       (axi_rlast && (beat_cnt != axi_arlen)) ||
                       (!axi_rlast && (beat_cnt == axi_arlen));

    // Fixed AR attributes
    assign axi_arid    = ID_V;
    assign axi_arsize  = ARSIZE;
    assign axi_arburst = 2'b01;
    assign axi_arlock  = 1'b0;
    assign axi_arcache = 4'b0011;
    assign axi_arprot  = 3'b000;
    assign axi_arqos   = 4'b0000;

    // R data goes straight through to the FIFO
    assign push_data = axi_rdata;

    // State register
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_ADDR;
            S_ADDR:  if (axi_arready) state_nxt = S_DATA;
            S_DATA:  if (accept && last_beat) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from the current state
    always_comb begin
        axi_arvalid  = (state == S_ADDR);
        axi_rready   = (state == S_DATA) && !sink_almost_full;
        push_data_en = (state == S_DATA) && axi_rvalid && !sink_almost_full;
        push_last    = push_data_en && axi_rlast;
        req_done     = (state == S_DONE);
        pend_out     = (state != S_IDLE);
    end

    // Request latch, beat counter, accept pulse and sticky error
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            axi_araddr <= '0;
            axi_arlen  <= '0;
            beat_cnt   <= '0;
            req_resp   <= 1'b0;
            resp_err   <= 1'b0;
        end else begin
            req_resp <= start;
            if (start) begin
                axi_araddr <= req_addr;
                axi_arlen  <= req_len;
                beat_cnt   <= '0;
            end else if (accept) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            if (accept && beat_err) begin
                resp_err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/axi_inf_read_state_core.md
Name: axi_inf_read_state_core

Overview:
- AXI4 read-channel master core: the read-direction counterpart of the VDMA write state core.
- Accepts one burst request (address, length) from the read-side FIFO status controller and issues a single AR transaction.
- Accepts the R beats and pushes each one into the downstream stream FIFO, honouring that FIFO's almost-full backpressure.
- Shares the bus with a sibling write core through the pend_in/pend_out lock.

Parameters:
IDSIZE, 4, width of arid/rid
ID, 0, value driven on arid and expected on rid
LSIZE, 9, width of req_len/arlen
ASIZE, 29, address width
AXI_DSIZE, 256, AXI data width; arsize = log2(AXI_DSIZE/8)

Ports:
axi_aclk  in  1  single clock for all logic
axi_resetn  in  1  asynchronous active-low reset
read_req  in  1  level request; held by requester until req_resp
req_len  in  LSIZE  burst beats minus 1 (AXI encoding), sampled with req_resp
req_addr  in  ASIZE  burst start address, sampled with req_resp
req_resp  out  1  1-cycle pulse: request accepted
req_done  out  1  1-cycle pulse: final R beat accepted
pend_in  in  1  sibling core holds bus; blocks new acceptance
pend_out  out  1  this core holds bus (state != IDLE)
sink_almost_full  in  1  downstream FIFO almost full
push_data_en  out  1  write strobe to downstream FIFO
push_data  out  AXI_DSIZE  = axi_rdata (combinational pass-through)
push_last  out  1  = axi_rlast qualified by push_data_en
resp_err  out  1  sticky error flag
axi_arid  out  IDSIZE  constant ID
axi_araddr  out  ASIZE  latched req_addr
axi_arlen  out  LSIZE  latched req_len
axi_arsize  out  3  log2(AXI_DSIZE/8); 3'd5 at default
axi_arburst  out  2  2'b01 INCR
axi_arlock  out  1  0
axi_arcache  out  4  4'b0011
axi_arprot  out  3  0
axi_arqos  out  4  0
axi_arvalid  out  1  address valid
axi_arready  in  1  address ready
axi_rid  in  IDSIZE  read ID
axi_rdata  in  AXI_DSIZE  read data
axi_rresp  in  2  read response
axi_rlast  in  1  last beat
axi_rvalid  in  1  data valid
axi_rready  out  1  data ready

Behaviour:
Reset:
- Asynchronous; effective immediately, including mid-burst.
- State = IDLE; arvalid, req_resp, req_done, pend_out, resp_err, and the beat counter all 0.
- araddr/arlen 0.

FSM states: IDLE, ADDR, DATA, DONE.

IDLE:
- If read_req=1 and pend_in=0, go to ADDR next cycle: latch req_addr/req_len, clear beat counter.
- req_resp is high exactly during the first ADDR cycle.
- If pend_in=1 the request waits; no timeout.

ADDR:
- axi_arvalid=1. araddr/arlen stay stable until handshake.
- On arvalid&&arready, go to DATA next cycle; arvalid drops.

DATA:
- axi_rready = (state==DATA) && !sink_almost_full; combinational.
- Beat accepted when rvalid&&rready; then push_data_en=1 in the same cycle and the beat counter increments.
- On an accepted beat with rlast=1, go to DONE.

DONE:
- req_done=1 for one cycle, then IDLE.
- Minimum one IDLE cycle between bursts.
- Latency read_req→arvalid: 1 cycle.

Error flag (resp_err), set sticky until reset on any accepted beat where:
- rresp != 2'b00, or
- rid != ID, or
- rlast=1 with counter != arlen, or
- counter == arlen with rlast=0 (treated as rlast; burst terminates).

Signal rules:
- read_req seen outside IDLE is ignored.
- pend_out = state != IDLE, registered; 1 from the first ADDR cycle through DONE inclusive.
- sink_almost_full may toggle any cycle; rready follows it the same cycle.
- Beats arriving while rready=0 are not pushed.
- Counter width LSIZE; cannot wrap because of the forced termination at counter == arlen.

Test Plan:
- Basic burst: read_req, req_addr=0x100, req_len=7, arready immediate, 8 rvalid beats with rlast on 8th → arvalid 1 cycle after req; 8 push_data_en pulses; req_done 1 cycle after beat 8; pend_out low after DONE; resp_err=0.
- Backpressure: sink_almost_full=1 for beats 3–5 of a len=15 burst → rready=0 for those cycles, no push; 16 pushes total; data order preserved.
- Arbitration: pend_in=1 with read_req held 10 cycles → no arvalid, no req_resp; pend_in drops → req_resp next cycle.
- Error: rresp=2'b10 on beat 2 → resp_err=1 and stays 1 after burst. Second case: rlast on beat 4 of len=7 → resp_err=1, req_done after beat 4.
- ARREADY stall: arready low 5 cycles → araddr/arlen stable, arvalid held, rready=0 throughout.
- Reset mid-DATA: axi_resetn low after beat 3 → arvalid/rready/pend_out 0 immediately; after release, a new len=0 request completes in one beat.
